// File: rtl/asip_pkg.sv
// Constants shared by the immediate packer and the Extender decoder.
// Both sides import these so the field placement cannot drift apart.
package asip_pkg;

  typedef enum logic [1:0] {FMT_NONE, FMT_I19, FMT_I23, FMT_I27} imm_fmt_t;

  localparam int OPC_W   = 5;
  localparam int FIELD_W = 27;
  localparam int REGS_W  = 8;
  localparam int WORD_W  = 32;

  localparam int I19_W  = 19;
  localparam int I23_W  = 23;
  localparam int I27_W  = 27;
  localparam int I19_SH = 8;
  localparam int I23_SH = 4;
  localparam int I27_SH = 0;

  // True when imm has no bit set at or above position w.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned w);
    return (imm >> w) == 32'd0;
  endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Request and output handshake bundle of the immediate packer.
// master drives requests and the output ready; slave is the packer.
interface imm_packer_if;
  import asip_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OPC_W-1:0]    opcode;
  imm_fmt_t            sel;
  logic [REGS_W-1:0]   regs;
  logic [31:0]         imm;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_word;

  modport master (
    output in_valid, opcode, sel, regs, imm, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, opcode, sel, regs, imm, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; when empty the read port keeps showing the last
// popped entry so the output word never changes without a pop.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/imm_packer.sv
// Packs opcode, register fields and an immediate into an ASIP word, drops
// out-of-range immediates with an error pulse and buffers words in a FIFO.
module imm_packer
  import asip_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  imm_packer_if.slave     bus,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);
  logic [FIELD_W-1:0] field_d;
  logic               illegal_d;
  logic [ERRW-1:0]    err_count_d;
  logic [ERRW-1:0]    err_count_q;
  logic               err_pulse_q;
  logic               ready_en_q;
  logic               accept;
  logic               pop;
  logic               push;
  logic               full;
  logic               empty;

  // Field placement is the exact inverse of the Extender decode.
  always_comb begin
    field_d   = {19'b0, bus.regs};
    illegal_d = 1'b0;
    case (bus.sel)
      FMT_I19: begin
        field_d   = {bus.imm[18:0], bus.regs};
        illegal_d = !imm_fits(bus.imm, I19_W);
      end
      FMT_I23: begin
        field_d   = {bus.imm[22:0], bus.regs[3:0]};
        illegal_d = !imm_fits(bus.imm, I23_W);
      end
      FMT_I27: begin
        field_d   = bus.imm[26:0];
        illegal_d = !imm_fits(bus.imm, I27_W);
      end
      default: begin
        field_d   = {19'b0, bus.regs};
        illegal_d = 1'b0;
      end
    endcase
  end

  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.in_ready = ready_en_q && (!full || pop);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && !illegal_d;
  assign bus.out_valid = !empty;

  // Saturating count of dropped requests.
  always_comb begin
    err_count_d = err_count_q;
    if (accept && illegal_d && (err_count_q != {ERRW{1'b1}})) begin
      err_count_d = err_count_q + ERRW'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Ready enable, error pulse and error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      err_pulse_q <= accept && illegal_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  sync_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.opcode, field_d}),
    .rdata_o (bus.out_word),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer; a second instance with ERRW=2 sees the same
// stimulus so error-counter saturation is checked alongside normal operation.
module tb_imm_packer;
  import asip_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       err_pulse2;
  logic [1:0] err_count2;
  int         n_checks = 0;
  int         n_pass   = 0;

  imm_packer_if ifc ();
  imm_packer_if ifc2 ();

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.opcode    = ifc.opcode;
  assign ifc2.sel       = ifc.sel;
  assign ifc2.regs      = ifc.regs;
  assign ifc2.imm       = ifc.imm;
  assign ifc2.out_ready = ifc.out_ready;

  imm_packer #(.DEPTH(2), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  imm_packer #(.DEPTH(2), .ERRW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(ifc2.slave),
    .err_pulse(err_pulse2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] extend(input logic [26:0] f, input imm_fmt_t s);
    case (s)
      FMT_I19: return {13'b0, f[26:8]};
      FMT_I23: return {9'b0, f[26:4]};
      FMT_I27: return {5'b0, f};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [4:0] op, input imm_fmt_t s, input logic [7:0] r, input logic [31:0] im);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.opcode   = op;
    ifc.sel      = s;
    ifc.regs     = r;
    ifc.imm      = im;
    #1;
    while (!ifc.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ifc.in_ready) check("send_timeout", {31'b0, ifc.in_ready}, 32'd1);
    tick();
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.opcode    = 5'h0;
    ifc.sel       = FMT_NONE;
    ifc.regs      = 8'h0;
    ifc.imm       = 32'h0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("rst_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    check("rst_out_word", ifc.out_word, 32'h0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", {31'b0, ifc.in_ready}, 32'd1);

    // Format packing with opcode 3, regs A5, imm 1.
    ifc.out_ready = 1'b1;
    send(5'h3, FMT_I19, 8'hA5, 32'd1);
    check("i19_valid", {31'b0, ifc.out_valid}, 32'd1);
    check("i19_word", ifc.out_word, 32'h1800_01A5);
    check("i19_extend", extend(ifc.out_word[26:0], FMT_I19), 32'd1);
    send(5'h3, FMT_I23, 8'hA5, 32'd1);
    check("i23_word", ifc.out_word, 32'h1800_0015);
    check("i23_extend", extend(ifc.out_word[26:0], FMT_I23), 32'd1);
    send(5'h3, FMT_I27, 8'hA5, 32'd1);
    check("i27_word", ifc.out_word, 32'h1800_0001);
    check("i27_extend", extend(ifc.out_word[26:0], FMT_I27), 32'd1);
    tick();
    check("drain_valid", {31'b0, ifc.out_valid}, 32'd0);
    check("drain_hold_word", ifc.out_word, 32'h1800_0001);

    // Range errors.
    send(5'h3, FMT_I19, 8'hA5, 32'h0008_0000);
    check("rerr1_pulse", {31'b0, err_pulse}, 32'd1);
    check("rerr1_count", {24'b0, err_count}, 32'd1);
    check("rerr1_no_write", {31'b0, ifc.out_valid}, 32'd0);
    tick();
    check("rerr1_pulse_end", {31'b0, err_pulse}, 32'd0);
    send(5'h3, FMT_I27, 8'hA5, 32'h0800_0000);
    check("rerr2_count", {24'b0, err_count}, 32'd2);
    check("rerr2_sat_count", {30'b0, err_count2}, 32'd2);
    send(5'h3, FMT_NONE, 8'hA5, 32'hFFFF_FFFF);
    check("none_word", ifc.out_word, 32'h1800_00A5);
    check("none_no_pulse", {31'b0, err_pulse}, 32'd0);
    check("none_count", {24'b0, err_count}, 32'd2);
    tick();

    // Backpressure: fill, then push and pop in one cycle.
    ifc.out_ready = 1'b0;
    send(5'h1, FMT_NONE, 8'h11, 32'h0);
    send(5'h2, FMT_NONE, 8'h22, 32'h0);
    check("full_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    check("full_head", ifc.out_word, 32'h0800_0011);
    tick();
    check("stall_head", ifc.out_word, 32'h0800_0011);
    check("stall_valid", {31'b0, ifc.out_valid}, 32'd1);
    ifc.in_valid  = 1'b1;
    ifc.opcode    = 5'h4;
    ifc.sel       = FMT_NONE;
    ifc.regs      = 8'h33;
    ifc.out_ready = 1'b1;
    #1;
    check("full_pop_ready", {31'b0, ifc.in_ready}, 32'd1);
    tick();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    #1;
    check("swap_head", ifc.out_word, 32'h1000_0022);
    check("swap_still_full", {31'b0, ifc.in_ready}, 32'd0);
    ifc.out_ready = 1'b1;
    tick();
    check("drain_c", ifc.out_word, 32'h2000_0033);
    check("drain_c_valid", {31'b0, ifc.out_valid}, 32'd1);
    tick();
    check("drained", {31'b0, ifc.out_valid}, 32'd0);

    // Saturation on the ERRW=2 instance while the 8-bit one keeps counting.
    for (int k = 0; k < 5; k++) begin
      send(5'h3, FMT_I23, 8'h00, 32'h0080_0000);
      check($sformatf("sat_count_%0d", k), {30'b0, err_count2}, (k == 0) ? 32'd3 : 32'd3);
      check($sformatf("wide_count_%0d", k), {24'b0, err_count}, 32'(3 + k));
      check($sformatf("sat_pulse_%0d", k), {31'b0, err_pulse2}, 32'd1);
    end
    tick();

    // Reset mid-stream with two queued words.
    ifc.out_ready = 1'b0;
    send(5'h6, FMT_NONE, 8'h44, 32'h0);
    send(5'h7, FMT_NONE, 8'h55, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    check("mid_rst_word", ifc.out_word, 32'h0);
    check("mid_rst_count", {24'b0, err_count}, 32'd0);
    check("mid_rst_ready", {31'b0, ifc.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ifc.out_ready = 1'b1;
    send(5'h1F, FMT_I27, 8'h00, 32'h0123_4567);
    check("post_rst_valid", {31'b0, ifc.out_valid}, 32'd1);
    check("post_rst_word", ifc.out_word, 32'hF923_4567);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
